// File: rtl/squash_shift_pkg.sv
// Shared defaults and FSM encoding for the squash_shift element packer.
package squash_shift_pkg;

  localparam int TOTAL_WIDTH_DEF  = 128;
  localparam int SQUASH_WIDTH_DEF = 8;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

endpackage

// File: rtl/squash_shift.sv
// Packs SQUASH_WIDTH-bit elements into a TOTAL_WIDTH frame presented as two halves.
// state | meaning
// FILL  | accepting elements into the accumulator
// FULL  | holding an assembled frame until the consumer takes it
module squash_shift
  import squash_shift_pkg::*;
#(
  parameter int TOTAL_WIDTH  = TOTAL_WIDTH_DEF,
  parameter int SQUASH_WIDTH = SQUASH_WIDTH_DEF,
  localparam int N  = TOTAL_WIDTH / SQUASH_WIDTH,
  localparam int CW = $clog2(N) + 1
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [SQUASH_WIDTH-1:0]   elem_i,
  input  logic                      elem_valid_i,
  output logic                      elem_ready_o,
  input  logic                      flush_i,
  output logic [TOTAL_WIDTH/2-1:0]  first_op_o,
  output logic [TOTAL_WIDTH/2-1:0]  second_op_o,
  output logic                      op_valid_o,
  input  logic                      op_ready_i,
  output logic [CW-1:0]             count_o
);

  localparam logic [CW-1:0] N_C = CW'(N);

  state_e                  state_q, state_d;
  logic [TOTAL_WIDTH-1:0]  acc_q, acc_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    accept;
  logic [CW-1:0]           count_inc;

  assign accept    = elem_valid_i && (state_q == FILL);
  assign count_inc = count_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= FILL;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          acc_d   = {acc_q[TOTAL_WIDTH-SQUASH_WIDTH-1:0], elem_i};
          count_d = count_inc;
          if ((count_inc == N_C) || flush_i) begin
            state_d = FULL;
          end
        end else if (flush_i && (count_q != '0)) begin
          state_d = FULL;
        end
      end
      FULL: begin
        // Release clears the frame; no element is taken on this edge.
        if (op_ready_i) begin
          acc_d   = '0;
          count_d = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign elem_ready_o = (state_q == FILL);
  assign op_valid_o   = (state_q == FULL);
  assign first_op_o   = acc_q[TOTAL_WIDTH-1:TOTAL_WIDTH/2];
  assign second_op_o  = acc_q[TOTAL_WIDTH/2-1:0];
  assign count_o      = count_q;

endmodule

// File: tb/tb_squash_shift.sv
// Scoreboard bench for squash_shift: directed frames plus a randomized run.
module tb_squash_shift;

  logic         clk_i = 1'b0;
  logic         rst_n_i;
  logic [7:0]   elem_i;
  logic         elem_valid_i;
  logic         elem_ready_o;
  logic         flush_i;
  logic [63:0]  first_op_o;
  logic [63:0]  second_op_o;
  logic         op_valid_o;
  logic         op_ready_i;
  logic [4:0]   count_o;

  typedef struct packed {
    logic [63:0] f;
    logic [63:0] s;
    logic [4:0]  c;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  squash_shift dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .elem_i       (elem_i),
    .elem_valid_i (elem_valid_i),
    .elem_ready_o (elem_ready_o),
    .flush_i      (flush_i),
    .first_op_o   (first_op_o),
    .second_op_o  (second_op_o),
    .op_valid_o   (op_valid_o),
    .op_ready_i   (op_ready_i),
    .count_o      (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] e, input logic f, input logic r);
    elem_valid_i = v;
    elem_i       = e;
    flush_i      = f;
    op_ready_i   = r;
    @(posedge clk_i);
    #2;
  endtask

  task automatic push_exp(input logic [63:0] f, input logic [63:0] s, input logic [4:0] c);
    exp_t x;
    x.f = f;
    x.s = s;
    x.c = c;
    sb.push_back(x);
  endtask

  task automatic drain(input string n);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 50) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      k++;
    end
    chk(n, 128'(sb.size()), 128'd0);
  endtask

  // Monitor: compares every presented frame against the queue head.
  always @(negedge clk_i) begin
    if (rst_n_i) begin
      chk("ready_vs_valid", 128'(elem_ready_o), 128'(!op_valid_o));
      if (op_valid_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_frame", 128'(op_valid_o), 128'd0);
        end else begin
          chk("frame_first", 128'(first_op_o), 128'(sb[0].f));
          chk("frame_second", 128'(second_op_o), 128'(sb[0].s));
          chk("frame_count", 128'(count_o), 128'(sb[0].c));
          if (op_ready_i) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    logic        mfull;
    logic [7:0]  mq[$];
    logic [127:0] val;
    logic        v, f, r;
    logic [7:0]  e;
    int          frames;
    int          cyc;

    rst_n_i      = 1'b0;
    elem_i       = '0;
    elem_valid_i = 1'b0;
    flush_i      = 1'b0;
    op_ready_i   = 1'b0;
    #3;
    chk("rst_first", 128'(first_op_o), 128'd0);
    chk("rst_second", 128'(second_op_o), 128'd0);
    chk("rst_count", 128'(count_o), 128'd0);
    chk("rst_valid", 128'(op_valid_o), 128'd0);
    chk("rst_ready", 128'(elem_ready_o), 128'd1);
    #10 rst_n_i = 1'b1;

    // Back-to-back full frame, consumer always ready.
    push_exp(64'h0001020304050607, 64'h08090A0B0C0D0E0F, 5'd16);
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b1);
    chk("full_latency_valid", 128'(op_valid_o), 128'd1);
    drain("t1_drain");

    // Same frame with a 5-cycle stall; stray inputs during FULL ignored.
    push_exp(64'h0001020304050607, 64'h08090A0B0C0D0E0F, 5'd16);
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'hFF, 1'b1, 1'b0);
    chk("stall_ready_low", 128'(elem_ready_o), 128'd0);
    cycle(1'b1, 8'h77, 1'b0, 1'b1);
    chk("after_release_count", 128'(count_o), 128'd0);

    // Partial frame closed by flush; also proves the release element was dropped.
    push_exp(64'h0, 64'h0000000000AABBCC, 5'd3);
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    cycle(1'b1, 8'hBB, 1'b0, 1'b0);
    cycle(1'b1, 8'hCC, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    drain("t3_drain");

    // Flush on an empty frame is ignored; flush with accept includes the element.
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    chk("empty_flush_valid", 128'(op_valid_o), 128'd0);
    push_exp(64'h0, 64'h55, 5'd1);
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    drain("t4_drain");

    // Reset in the middle of a frame.
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'hE0 + i), 1'b0, 1'b1);
    chk("pre_reset_count", 128'(count_o), 128'd7);
    rst_n_i = 1'b0;
    #1;
    chk("async_rst_second", 128'(second_op_o), 128'd0);
    chk("async_rst_count", 128'(count_o), 128'd0);
    chk("async_rst_ready", 128'(elem_ready_o), 128'd1);
    #4 rst_n_i = 1'b1;
    push_exp(64'h1011121314151617, 64'h18191A1B1C1D1E1F, 5'd16);
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b1);
    drain("t5_drain");

    // Randomized traffic: model collects accepted elements per frame.
    mfull  = 1'b0;
    frames = 0;
    cyc    = 0;
    while (frames < 1000 && cyc < 60000) begin
      v = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 1) == 1);
      f = ($urandom_range(0, 39) == 0);
      e = 8'($urandom_range(0, 255));
      if (!mfull) begin
        if (v) mq.push_back(e);
        if ((v && mq.size() == 16) || (f && mq.size() > 0)) begin
          val = '0;
          foreach (mq[k]) val = {val[119:0], mq[k]};
          push_exp(val[127:64], val[63:0], 5'(mq.size()));
          mq.delete();
          mfull = 1'b1;
          frames++;
        end
      end else if (r) begin
        mfull = 1'b0;
      end
      cycle(v, e, f, r);
      cyc++;
      if ((cyc % 97) == 0) chk("rand_ready_model", 128'(elem_ready_o), 128'(!mfull));
    end
    chk("rand_frames", 128'(frames), 128'd1000);
    drain("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
